// File: rtl/imem_loader_pkg.sv
// Shared types and constants for the instruction-memory loader.
package imem_loader_pkg;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    RECV  = 3'd1,
    WRITE = 3'd2,
    CHECK = 3'd3,
    DONE  = 3'd4
  } state_t;

  localparam int BYTES_PER_WORD  = 4;
  localparam int WORD_ADDR_SHIFT = 2;

endpackage

// File: rtl/imem_loader_byte_assembler.sv
// Packs accepted bytes little-endian into a 32-bit word; word/word_ready
// present the completed word combinationally on the 4th accepted byte.
module byte_assembler
  import imem_loader_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic        clear,
  input  logic        accept,
  input  logic [7:0]  byte_data,
  output logic [31:0] word,
  output logic        word_ready
);

  logic [1:0]  idx_reg;
  logic [31:0] word_reg;

  // Each lane takes the incoming byte only when the index points at it.
  generate
    for (genvar gi = 0; gi < BYTES_PER_WORD; gi++) begin : g_lane
      assign word[8*gi +: 8] = (accept && (idx_reg == 2'(gi))) ? byte_data
                                                               : word_reg[8*gi +: 8];
    end
  endgenerate

  assign word_ready = accept && (idx_reg == 2'(BYTES_PER_WORD - 1));

  always_ff @(posedge clk) begin
    if (reset || clear) begin
      idx_reg  <= 2'd0;
      word_reg <= 32'd0;
    end else if (accept) begin
      idx_reg  <= idx_reg + 2'd1;
      word_reg <= word;
    end
  end

endmodule

// File: rtl/imem_loader.sv
// Streams program bytes into instruction memory while holding the core.
// Optional trailing-checksum byte: define IMEM_LOADER_CHECKSUM_EN.
module imem_loader
  import imem_loader_pkg::*;
#(
  parameter int          DEPTH_WORDS = 64,
  parameter logic [31:0] BASE_ADDR   = 32'h0000_0000,
  parameter int          LEN_WIDTH   = 16
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 start,
  input  logic [LEN_WIDTH-1:0] len_words,
  input  logic                 byte_valid,
  input  logic [7:0]           byte_data,
  output logic                 byte_ready,
  output logic                 mem_write,
  output logic [31:0]          mem_address,
  output logic [31:0]          mem_write_data,
  output logic                 cpu_hold,
  output logic                 busy,
  output logic                 done,
  output logic                 error
);

  state_t state_reg, state_next;

  logic [LEN_WIDTH-1:0] len_reg;
  logic [LEN_WIDTH-1:0] word_idx_reg;
  logic [31:0]          mem_address_reg;
  logic [31:0]          mem_write_data_reg;
  logic                 byte_ready_reg, mem_write_reg, cpu_hold_reg;
  logic                 busy_reg, done_reg, error_reg, error_next;

  logic        start_ok, start_zero, start_big, accept, clear;
  logic [31:0] word;
  logic        word_ready;

  assign start_zero = start && (len_words == '0);
  assign start_ok   = start && !start_zero && (32'(len_words) <= 32'(DEPTH_WORDS));
  assign start_big  = start && !start_zero && !start_ok;
  assign accept     = byte_valid && (state_reg == RECV);
  assign clear      = (state_reg == IDLE) && start_ok;

`ifdef IMEM_LOADER_CHECKSUM_EN
  logic [7:0] csum_reg;

  always_ff @(posedge clk) begin
    if (reset || clear) begin
      csum_reg <= 8'd0;
    end else if (accept) begin
      csum_reg <= csum_reg ^ byte_data;
    end
  end
`endif

  byte_assembler u_assembler (
    .clk        (clk),
    .reset      (reset),
    .clear      (clear),
    .accept     (accept),
    .byte_data  (byte_data),
    .word       (word),
    .word_ready (word_ready)
  );

  always_comb begin
    state_next = state_reg;
    error_next = error_reg;
    case (state_reg)
      IDLE: begin
        if (start_big) begin
          error_next = 1'b1;
        end else if (start_ok) begin
          error_next = 1'b0;
          state_next = RECV;
        end else if (start_zero) begin
          error_next = 1'b0;
          state_next = DONE;
        end
      end
      RECV: begin
        if (word_ready) state_next = WRITE;
      end
      WRITE: begin
        // word_idx_reg was already advanced when this write was captured.
        if (word_idx_reg == len_reg) begin
`ifdef IMEM_LOADER_CHECKSUM_EN
          state_next = CHECK;
`else
          state_next = DONE;
`endif
        end else begin
          state_next = RECV;
        end
      end
`ifdef IMEM_LOADER_CHECKSUM_EN
      CHECK: begin
        if (byte_valid) begin
          state_next = DONE;
          if (byte_data != csum_reg) error_next = 1'b1;
        end
      end
`endif
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg          <= IDLE;
      len_reg            <= '0;
      word_idx_reg       <= '0;
      mem_address_reg    <= 32'd0;
      mem_write_data_reg <= 32'd0;
      byte_ready_reg     <= 1'b0;
      mem_write_reg      <= 1'b0;
      cpu_hold_reg       <= 1'b0;
      busy_reg           <= 1'b0;
      done_reg           <= 1'b0;
      error_reg          <= 1'b0;
    end else begin
      state_reg      <= state_next;
      error_reg      <= error_next;
      // All status outputs are registered copies of the upcoming state.
      byte_ready_reg <= (state_next == RECV) || (state_next == CHECK);
      mem_write_reg  <= (state_next == WRITE);
      cpu_hold_reg   <= (state_next == RECV) || (state_next == WRITE) ||
                        (state_next == CHECK);
      busy_reg       <= (state_next != IDLE);
      done_reg       <= (state_next == DONE);
      if (clear) begin
        len_reg      <= len_words;
        word_idx_reg <= '0;
      end
      if (word_ready) begin
        mem_address_reg    <= BASE_ADDR + (32'(word_idx_reg) << WORD_ADDR_SHIFT);
        mem_write_data_reg <= word;
        word_idx_reg       <= word_idx_reg + LEN_WIDTH'(1);
      end
    end
  end

  assign byte_ready     = byte_ready_reg;
  assign mem_write      = mem_write_reg;
  assign mem_address    = mem_address_reg;
  assign mem_write_data = mem_write_data_reg;
  assign cpu_hold       = cpu_hold_reg;
  assign busy           = busy_reg;
  assign done           = done_reg;
  assign error          = error_reg;

endmodule
